// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } state_t;

    // Bit positions inside RST_CAUSE.
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_PLL = 1;
    localparam int CAUSE_BTN = 2;
    localparam int CAUSE_SW  = 3;

    // Value RST_CAUSE takes while PORESETn is low.
    localparam logic [3:0] CAUSE_RESET = 4'(1 << CAUSE_POR);

    // A counter that must hold the value v itself needs one bit of headroom.
    function automatic int cnt_width(input int unsigned v);
        return $clog2(v) + 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Multi-flop synchroniser for one asynchronous level input, cleared to 0 by reset.
// Latency: STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: hclk - sampling clock; reset_n - async active-low clear;
//        d - async input; q - synchronised output.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic hclk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge hclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: merges POR, debounced button, PLL lock and a software request, stretches, then releases domains in order.
// Latency: RSTn_OUT[k] rises STRETCH+1+k*STAGE_GAP edges after the last source goes inactive; SW request acts in 1 cycle.
// Backpressure: none; all inputs are level/pulse sampled every cycle, all outputs registered.
// Ports: CLK - clock; PORESETn - async active-low power-on reset; BTN_RESET / PLL_LOCKED - async inputs;
//        SW_RESET_REQ - synchronous request pulse; CAUSE_CLR - clears RST_CAUSE;
//        RSTn_OUT - per-domain active-low resets; SEQ_DONE - all domains released; RST_CAUSE - sticky {SW,BTN,PLL,POR}.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned        NUM_OUT     = 3,
    parameter int unsigned        STRETCH     = 255,
    parameter int unsigned        STAGE_GAP   = 16,
    parameter int unsigned        DEBOUNCE    = 1024,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_OUT-1:0] SW_KEEP     = '0
) (
    input  logic               CLK,
    input  logic               PORESETn,
    input  logic               BTN_RESET,
    input  logic               PLL_LOCKED,
    input  logic               SW_RESET_REQ,
    input  logic               CAUSE_CLR,
    output logic [NUM_OUT-1:0] RSTn_OUT,
    output logic               SEQ_DONE,
    output logic [3:0]         RST_CAUSE
);

    localparam int STR_W = cnt_width(STRETCH);
    localparam int GAP_W = cnt_width(STAGE_GAP);
    localparam int DEB_W = cnt_width(DEBOUNCE);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STAGE_GAP - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

    logic btn_sync;
    logic pll_sync;

    rst_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
        .hclk    (CLK),
        .reset_n (PORESETn),
        .d       (BTN_RESET),
        .q       (btn_sync)
    );

    rst_sync #(.STAGES(SYNC_STAGES)) u_pll_sync (
        .hclk    (CLK),
        .reset_n (PORESETn),
        .d       (PLL_LOCKED),
        .q       (pll_sync)
    );

    state_t             state_q,   state_d;
    logic [STR_W-1:0]   cnt_q,     cnt_d;
    logic [GAP_W-1:0]   gap_q,     gap_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [DEB_W-1:0]   deb_q,     deb_d;
    logic [NUM_OUT-1:0] rst_q,     rst_d;
    logic               done_q,    done_d;
    logic               sw_only_q, sw_only_d;
    logic [3:0]         cause_q,   cause_d;

    logic btn_active;
    logic pll_active;
    logic hw_active;
    logic any_active;
    logic cause_evt;

    assign btn_active = (deb_q == DEB_MAX);
    assign pll_active = ~pll_sync;
    assign hw_active  = btn_active | pll_active;
    assign any_active = hw_active | SW_RESET_REQ;

    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q   <= ASSERT;
            cnt_q     <= STR_LOAD;
            gap_q     <= '0;
            idx_q     <= '0;
            deb_q     <= '0;
            rst_q     <= '0;
            done_q    <= 1'b0;
            sw_only_q <= 1'b0;
            cause_q   <= CAUSE_RESET;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            deb_q     <= deb_d;
            rst_q     <= rst_d;
            done_q    <= done_d;
            sw_only_q <= sw_only_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        rst_d     = rst_q;
        done_d    = done_q;
        sw_only_d = sw_only_q;
        cause_evt = 1'b0;

        // Debounce: count while the synchronised button is high, saturate at DEBOUNCE.
        if (!btn_sync) begin
            deb_d = '0;
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + DEB_W'(1);
        end else begin
            deb_d = deb_q;
        end

        case (state_q)
            ASSERT: begin
                if (any_active) begin
                    cnt_d = STR_LOAD;
                    // A reload that leaves the counter at its load value (synchroniser fill after
                    // power-on, a source simply staying active) is not a fresh event; a hardware
                    // source overriding a software-only hold always is.
                    cause_evt = (cnt_q != STR_LOAD) || (hw_active && sw_only_q);
                    if (hw_active) begin
                        rst_d     = '0;
                        sw_only_d = 1'b0;
                    end
                end else if (cnt_q == '0) begin
                    rst_d[0]  = 1'b1;
                    sw_only_d = 1'b0;
                    gap_d     = GAP_LOAD;
                    idx_d     = IDX_W'(1);
                    if (NUM_OUT == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - STR_W'(1);
                end
            end

            default: begin
                if (any_active) begin
                    cause_evt = 1'b1;
                    state_d   = ASSERT;
                    cnt_d     = STR_LOAD;
                    done_d    = 1'b0;
                    if (hw_active) begin
                        rst_d     = '0;
                        sw_only_d = 1'b0;
                    end else begin
                        // Kept domains hold their level; re-asserting them high in their
                        // release slot later is then a no-op, so slot timing is unchanged.
                        rst_d     = rst_q & SW_KEEP;
                        sw_only_d = 1'b1;
                    end
                end else if (state_q == RELEASE) begin
                    if (gap_q == '0) begin
                        rst_d[idx_q] = 1'b1;
                        gap_d        = GAP_LOAD;
                        idx_d        = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
            end
        endcase

        // Clear first so a same-cycle set wins.
        cause_d = CAUSE_CLR ? 4'b0000 : cause_q;
        if (cause_evt) begin
            if (pll_active)   cause_d[CAUSE_PLL] = 1'b1;
            if (btn_active)   cause_d[CAUSE_BTN] = 1'b1;
            if (SW_RESET_REQ) cause_d[CAUSE_SW]  = 1'b1;
        end
    end

    assign RSTn_OUT  = rst_q;
    assign SEQ_DONE  = done_q;
    assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

    logic       CLK = 1'b0;
    logic       PORESETn;
    logic       BTN_RESET;
    logic       PLL_LOCKED;
    logic       SW_RESET_REQ;
    logic       CAUSE_CLR;
    logic [2:0] RSTn_OUT;
    logic       SEQ_DONE;
    logic [3:0] RST_CAUSE;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         at;
        logic [2:0] rst;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    rst_seq #(
        .NUM_OUT     (3),
        .STRETCH     (255),
        .STAGE_GAP   (16),
        .DEBOUNCE    (1024),
        .SYNC_STAGES (2),
        .SW_KEEP     (3'b001)
    ) dut (
        .CLK          (CLK),
        .PORESETn     (PORESETn),
        .BTN_RESET    (BTN_RESET),
        .PLL_LOCKED   (PLL_LOCKED),
        .SW_RESET_REQ (SW_RESET_REQ),
        .CAUSE_CLR    (CAUSE_CLR),
        .RSTn_OUT     (RSTn_OUT),
        .SEQ_DONE     (SEQ_DONE),
        .RST_CAUSE    (RST_CAUSE)
    );

    always #5 CLK = ~CLK;

    // Expected outputs n edges after the stimulus of the current scenario.
    task automatic push(input int at, input logic [2:0] rst, input logic done);
        exp_t x;
        x.at   = at;
        x.rst  = rst;
        x.done = done;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        PORESETn = 1'b0; BTN_RESET = 1'b0; PLL_LOCKED = 1'b1;
        SW_RESET_REQ = 1'b0; CAUSE_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (RSTn_OUT !== 3'b000) $display("FAIL reset_rstn: got %b want 000", RSTn_OUT); else passes++;
        checks++;
        if (SEQ_DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", SEQ_DONE); else passes++;
        checks++;
        if (RST_CAUSE !== 4'b0001) $display("FAIL reset_cause: got %b want 0001", RST_CAUSE); else passes++;
    endtask

    task automatic test_power_up();
        exp_t e;
        PORESETn = 1'b1;
        push(257, 3'b000, 1'b0); push(258, 3'b001, 1'b0); push(273, 3'b001, 1'b0);
        push(274, 3'b011, 1'b0); push(289, 3'b011, 1'b0); push(290, 3'b111, 1'b1);
        for (int n = 1; n <= 290; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL power_up @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
        end
        checks++;
        if (RST_CAUSE !== 4'b0001) $display("FAIL power_up_cause: got %b want 0001", RST_CAUSE); else passes++;
    endtask

    task automatic test_btn_glitch();
        exp_t e;
        BTN_RESET = 1'b1;
        push(999, 3'b111, 1'b1); push(1040, 3'b111, 1'b1);
        for (int n = 1; n <= 1040; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL btn_glitch @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
            if (n == 1000) BTN_RESET = 1'b0;
        end
        checks++;
        if (RST_CAUSE !== 4'b0001) $display("FAIL btn_glitch_cause: got %b want 0001", RST_CAUSE); else passes++;
    endtask

    task automatic test_btn_hold();
        exp_t e;
        BTN_RESET = 1'b1;
        push(1025, 3'b111, 1'b1); push(1027, 3'b000, 1'b0); push(1288, 3'b000, 1'b0);
        push(1289, 3'b001, 1'b0); push(1305, 3'b011, 1'b0); push(1320, 3'b011, 1'b0);
        push(1321, 3'b111, 1'b1);
        for (int n = 1; n <= 1321; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL btn_hold @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
            if (n == 1030) BTN_RESET = 1'b0;
        end
        checks++;
        if (RST_CAUSE !== 4'b0101) $display("FAIL btn_hold_cause: got %b want 0101", RST_CAUSE); else passes++;
    endtask

    task automatic test_pll_glitch();
        exp_t e;
        PLL_LOCKED = 1'b0;
        push(2, 3'b111, 1'b1); push(3, 3'b000, 1'b0); push(258, 3'b000, 1'b0);
        push(259, 3'b001, 1'b0); push(275, 3'b011, 1'b0); push(291, 3'b111, 1'b1);
        for (int n = 1; n <= 291; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL pll_glitch @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
            if (n == 1) PLL_LOCKED = 1'b1;
        end
        checks++;
        if (RST_CAUSE !== 4'b0111) $display("FAIL pll_glitch_cause: got %b want 0111", RST_CAUSE); else passes++;
    endtask

    task automatic test_sw_keep();
        exp_t e;
        logic dropped = 1'b0;
        SW_RESET_REQ = 1'b1;
        push(1, 3'b001, 1'b0); push(256, 3'b001, 1'b0); push(272, 3'b001, 1'b0);
        push(273, 3'b011, 1'b0); push(288, 3'b011, 1'b0); push(289, 3'b111, 1'b1);
        for (int n = 1; n <= 289; n++) begin
            @(posedge CLK); #1;
            if (RSTn_OUT[0] !== 1'b1) dropped = 1'b1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL sw_keep @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
            if (n == 1) SW_RESET_REQ = 1'b0;
        end
        checks++;
        if (dropped !== 1'b0) $display("FAIL sw_keep_dom0: got dropped=%b want 0", dropped); else passes++;
        checks++;
        if (RST_CAUSE !== 4'b1111) $display("FAIL sw_keep_cause: got %b want 1111", RST_CAUSE); else passes++;
    endtask

    task automatic test_sw_then_pll();
        exp_t e;
        CAUSE_CLR = 1'b1;
        @(posedge CLK); #1;
        CAUSE_CLR = 1'b0;
        checks++;
        if (RST_CAUSE !== 4'b0000) $display("FAIL cause_clr: got %b want 0000", RST_CAUSE); else passes++;
        SW_RESET_REQ = 1'b1;
        push(1, 3'b001, 1'b0); push(12, 3'b001, 1'b0); push(13, 3'b000, 1'b0);
        push(268, 3'b000, 1'b0); push(269, 3'b001, 1'b0); push(285, 3'b011, 1'b0);
        push(301, 3'b111, 1'b1);
        for (int n = 1; n <= 301; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL sw_then_pll @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
            if (n == 1)  SW_RESET_REQ = 1'b0;
            if (n == 10) PLL_LOCKED = 1'b0;
            if (n == 11) PLL_LOCKED = 1'b1;
        end
        checks++;
        if (RST_CAUSE !== 4'b1010) $display("FAIL sw_then_pll_cause: got %b want 1010", RST_CAUSE); else passes++;
    endtask

    // CAUSE_CLR stays high up to and including the edge on which the button takes effect.
    task automatic test_cause_clr_race();
        logic got = 1'b0;
        BTN_RESET = 1'b1;
        CAUSE_CLR = 1'b1;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge CLK); #1;
            if (RSTn_OUT === 3'b000) begin
                got = 1'b1;
                break;
            end
        end
        CAUSE_CLR = 1'b0;
        checks++;
        if (!got || RST_CAUSE !== 4'b0100)
            $display("FAIL clr_race: got triggered=%b cause=%b want 1/0100", got, RST_CAUSE);
        else passes++;
        BTN_RESET = 1'b0;
        got = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge CLK); #1;
            if (SEQ_DONE === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) $display("FAIL clr_race_rerun: got SEQ_DONE=%b want 1 within 2000 cycles", SEQ_DONE); else passes++;
    endtask

    task automatic test_por_mid_release();
        exp_t e;
        PLL_LOCKED = 1'b0;
        push(259, 3'b001, 1'b0); push(265, 3'b001, 1'b0);
        for (int n = 1; n <= 265; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL por_pre @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
            if (n == 1) PLL_LOCKED = 1'b1;
        end
        PORESETn = 1'b0;
        #1;
        checks++;
        if (RSTn_OUT !== 3'b000) $display("FAIL por_async_rstn: got %b want 000", RSTn_OUT); else passes++;
        checks++;
        if (SEQ_DONE !== 1'b0) $display("FAIL por_async_done: got %b want 0", SEQ_DONE); else passes++;
        checks++;
        if (RST_CAUSE !== 4'b0001) $display("FAIL por_async_cause: got %b want 0001", RST_CAUSE); else passes++;
        @(posedge CLK); #1;
        PORESETn = 1'b1;
        push(257, 3'b000, 1'b0); push(258, 3'b001, 1'b0);
        for (int n = 1; n <= 258; n++) begin
            @(posedge CLK); #1;
            while (exp_q.size() > 0 && exp_q[0].at == n) begin
                e = exp_q.pop_front();
                checks++;
                if (RSTn_OUT !== e.rst || SEQ_DONE !== e.done)
                    $display("FAIL por_replay @%0d: got %b/%b want %b/%b", n, RSTn_OUT, SEQ_DONE, e.rst, e.done);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_btn_glitch();
        test_btn_hold();
        test_pll_glitch();
        test_sw_keep();
        test_sw_then_pll();
        test_cause_clr_race();
        test_por_mid_release();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
